remote_key_dispatcher: RTL

Sequencing and arbitration stage behind the IR remote receiver: captures each decoded key (Ready strobe + 8-bit Tecla), suppresses auto-repeat duplicates within a hold-off window, and buffers keys in a small FIFO. Keys are dispatched one at a time over a valid/ack handshake to one of two consumers: the numeric channel-entry unit (digit keys 0x00–0x09) or the command unit (all other codes, e.g. POWER 0x12, UP 0x1A). A watchdog abandons a key that its consumer never acknowledges. Runs on the receiver's 304 kHz system clock.

---
 rtl/remote_key_dispatcher_if.sv | 24 ++
 rtl/remote_key_dispatcher.sv | 122 ++++++++++++
 2 files changed

// File: rtl/remote_key_dispatcher_if.sv
// Key handshake bundle between the IR receiver, the dispatcher and its two consumers.
// master drives keys and acks; slave is the dispatcher.
interface remote_key_dispatcher_if;
  logic [7:0] tecla;
  logic       ready;
  logic [7:0] key_out;
  logic       num_valid;
  logic       num_ack;
  logic       cmd_valid;
  logic       cmd_ack;
  logic       overflow;
  logic       timeout;
  logic       busy;

  modport master (
    output tecla, ready, num_ack, cmd_ack,
    input  key_out, num_valid, cmd_valid, overflow, timeout, busy
  );

  modport slave (
    input  tecla, ready, num_ack, cmd_ack,
    output key_out, num_valid, cmd_valid, overflow, timeout, busy
  );
endinterface

// File: rtl/remote_key_dispatcher.sv
// Captures decoded remote keys, drops auto-repeats inside a hold-off window, buffers them
// and offers each to the numeric or command unit over valid/ack with an ack watchdog.
module remote_key_dispatcher #(
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned HoldoffCycles = 30400,
  parameter int unsigned TimeoutCycles = 3040
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  remote_key_dispatcher_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HoldW = $clog2(HoldoffCycles + 1);
  localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);
  localparam logic [7:0]  MaxDigit = 8'h09;

  typedef enum logic [0:0] {StIdle, StWaitAck} state_e;

  state_e           state_q;
  logic [7:0]       key_out_q;
  logic             num_valid_q, cmd_valid_q, timeout_q;
  logic [WaitW-1:0] wait_q;

  logic [7:0]       mem_q [FifoDepth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [7:0]       last_key_q, last_key_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             overflow_q, overflow_d;
  logic             dup, push_req, full, pop, push;
  logic [7:0]       head;

  always_comb begin
    head     = mem_q[rd_ptr_q];
    dup      = bus.ready && (bus.tecla == last_key_q) && (hold_q != '0);
    push_req = bus.ready && !dup;
    full     = (count_q == CntW'(FifoDepth));
    pop      = (state_q == StIdle) && (count_q != '0);
    // A full FIFO still accepts a key when the dispatcher frees a slot on the same edge.
    push       = push_req && (!full || pop);
    overflow_d = push_req && full && !pop;
    last_key_d = push_req ? bus.tecla : last_key_q;
    if (push_req) begin
      hold_d = HoldW'(HoldoffCycles);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end else begin
      hold_d = hold_q;
    end
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_key_q <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_key_q <= last_key_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q] <= bus.tecla;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      key_out_q   <= '0;
      num_valid_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            key_out_q   <= head;
            num_valid_q <= (head <= MaxDigit);
            cmd_valid_q <= (head > MaxDigit);
            wait_q      <= '0;
            state_q     <= StWaitAck;
          end
        end
        StWaitAck: begin
          // Ack is checked first so an ack on the deadline edge completes normally.
          if ((num_valid_q && bus.num_ack) || (cmd_valid_q && bus.cmd_ack)) begin
            num_valid_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else if (wait_q == WaitW'(TimeoutCycles - 1)) begin
            num_valid_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.key_out   = key_out_q;
  assign bus.num_valid = num_valid_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (count_q != '0) || (state_q == StWaitAck);
endmodule
